// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader on the write side of the instruction memory.
//   Receives a byte stream (valid/ready), assembles big-endian 32-bit words and
//   writes them to consecutive imem word addresses starting at 0. The CPU is
//   held (cpu_hold) while a load is in progress and after a failed load.
//
//   Frame: header byte N (word count), N*4 data bytes MSB first, and a
//   checksum byte (XOR of all data bytes) when CHECKSUM_EN is defined.
//
// Configuration macro:
//   CHECKSUM_EN  adds the running-XOR register and the CHK state.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     1-cycle pulse, begins a load from IDLE, DONE or ERR
//   rx_valid  stream byte available
//   rx_data   stream byte
//   rx_ready  loader accepts a byte this cycle
//   imem_we   imem write enable (single cycle per word)
//   imem_wa   imem word address (holds when imem_we=0)
//   imem_wd   imem write data   (holds when imem_we=0)
//   cpu_hold  keep CPU stalled
//   busy      load in progress
//   done      sticky: last load completed OK
//   error     sticky: last load failed
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_wa,
  output logic [31:0]       imem_wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Counters are one bit wider than the address so N == 2**ADDR_W fits.
  localparam int CW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      bcnt_reg;
  logic [CW-1:0]   widx_reg;
  logic [CW-1:0]   wcnt_reg;
  logic [23:0]     word_reg;

`ifdef CHECKSUM_EN
  logic [7:0]      csum_reg;
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  logic xfer;
  logic start_ok;
  logic last_word;
  logic hdr_big;

  // rx_ready is a registered decode of the state, so it is already 0 in every
  // state that must ignore rx_valid.
  assign xfer      = rx_valid & rx_ready;
  assign start_ok  = start & ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                              (state_reg == S_ERR));
  assign last_word = (widx_reg + CW'(1)) >= wcnt_reg;
  assign hdr_big   = 32'(rx_data) > 32'(DEPTH);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_next = S_HDR;
      S_HDR: begin
        if (xfer) begin
          if (rx_data == 8'h00) state_next = S_END;
          else if (hdr_big)     state_next = S_ERR;
          else                  state_next = S_DATA;
        end
      end
      S_DATA:  if (xfer && bcnt_reg == 2'd3) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_END : S_DATA;
      S_CHK: begin
        if (xfer) begin
`ifdef CHECKSUM_EN
          state_next = (rx_data == csum_reg) ? S_DONE : S_ERR;
`else
          state_next = S_ERR;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      rx_ready  <= 1'b0;
      imem_we   <= 1'b0;
      imem_wa   <= '0;
      imem_wd   <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      bcnt_reg  <= '0;
      widx_reg  <= '0;
      wcnt_reg  <= '0;
      word_reg  <= '0;
`ifdef CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;

      // Outputs decoded from the next state so they change together with it.
      rx_ready <= (state_next == S_HDR) || (state_next == S_DATA) ||
                  (state_next == S_CHK);
      imem_we  <= (state_next == S_WRITE);
      busy     <= (state_next == S_HDR) || (state_next == S_DATA) ||
                  (state_next == S_WRITE) || (state_next == S_CHK);
      cpu_hold <= !((state_next == S_IDLE) || (state_next == S_DONE));
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERR);

      if (start_ok) begin
        bcnt_reg <= '0;
        widx_reg <= '0;
        wcnt_reg <= '0;
`ifdef CHECKSUM_EN
        csum_reg <= '0;
`endif
      end

      if (state_reg == S_HDR && xfer && !hdr_big)
        wcnt_reg <= CW'(rx_data);

      if (state_reg == S_DATA && xfer) begin
        bcnt_reg <= bcnt_reg + 2'd1;
        word_reg <= {word_reg[15:0], rx_data};
`ifdef CHECKSUM_EN
        csum_reg <= csum_reg ^ rx_data;
`endif
        // Address and data are loaded only for a write, so they hold otherwise.
        if (bcnt_reg == 2'd3) begin
          imem_wa <= widx_reg[ADDR_W-1:0];
          imem_wd <= {word_reg, rx_data};
        end
      end

      if (state_reg == S_WRITE)
        widx_reg <= widx_reg + CW'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_wa;
  logic [31:0]       imem_wd;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rdy_viol = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  bit          exp_ok;

  // Observed imem writes, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      got_q.push_back({32'(imem_wa), imem_wd});
      if (rx_ready) rdy_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected writes and outcome straight from the frame bytes.
  function automatic void run_model();
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'(frame_q[0]);
    if (n > DEPTH) begin
      exp_ok = 1'b0;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({32'(k), frame_q[1+4*k], frame_q[2+4*k], frame_q[3+4*k], frame_q[4+4*k]});
      for (int j = 1; j <= 4; j++) x = x ^ frame_q[4*k+j];
    end
    exp_ok = 1'b1;
`ifdef CHECKSUM_EN
    exp_ok = (frame_q[1+4*n] == x);
`endif
  endfunction

  task automatic build_random(input int n);
    frame_q.delete();
    frame_q.push_back(8'(n));
    if (n <= DEPTH)
      for (int i = 0; i < 4*n; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic add_checksum(input bit bad);
`ifdef CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
    frame_q.push_back(bad ? (x ^ 8'h01) : x);
`else
    if (bad) frame_q.push_back(8'h00);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int  g;
    bit  ok;
    logic r;
    g = $urandom_range(maxgap, 0);
    rx_valid = 1'b0;
    repeat (g) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); r = rx_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1'b1; break; end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (!ok) check("rx_timeout", 64'(ok), 64'd1);
  endtask

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i < hi; i++) send_byte(frame_q[i], maxgap);
  endtask

  task automatic begin_frame(input string tag);
    run_model();
    got_q.delete();
    rdy_viol = 0;
    pulse_start();
    check({tag, "_busy0"}, 64'(busy), 64'd1);
    check({tag, "_hold0"}, 64'(cpu_hold), 64'd1);
    check({tag, "_done0"}, 64'(done), 64'd0);
    check({tag, "_err0"},  64'(error), 64'd0);
  endtask

  task automatic end_frame(input string tag);
    int m;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_done"}, 64'(done), 64'(exp_ok));
    check({tag, "_err"},  64'(error), 64'(!exp_ok));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(!exp_ok));
    check({tag, "_rdy_in_write"}, 64'(rdy_viol), 64'd0);
  endtask

  task automatic full_frame(input string tag, input int maxgap);
    begin_frame(tag);
    send_range(0, frame_q.size(), maxgap);
    end_frame(tag);
    $display("frame %s: N=%0d writes=%0d done=%0b error=%0b", tag, frame_q[0], got_q.size(), done, error);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_we"},       64'(imem_we), 64'd0);
    check({tag, "_wa"},       64'(imem_wa), 64'd0);
    check({tag, "_wd"},       64'(imem_wd), 64'd0);
    check({tag, "_hold"},     64'(cpu_hold), 64'd0);
    check({tag, "_busy"},     64'(busy), 64'd0);
    check({tag, "_done"},     64'(done), 64'd0);
    check({tag, "_error"},    64'(error), 64'd0);
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed two-word program.
    frame_q = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h3C};
    add_checksum(1'b0);
    full_frame("two_words", 0);

    // Full memory with random gaps, then one word too many.
    build_random(DEPTH);
    add_checksum(1'b0);
    full_frame("full_depth", 3);
    build_random(DEPTH + 1);
    full_frame("oversize", 1);

    // Empty program.
    frame_q = '{8'h00};
    add_checksum(1'b0);
    full_frame("empty", 0);

`ifdef CHECKSUM_EN
    frame_q = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    full_frame("csum_good", 0);
    frame_q = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    full_frame("csum_bad", 0);
`endif

    // A few random small programs.
    for (int t = 0; t < 4; t++) begin
      build_random($urandom_range(8, 1));
      add_checksum(1'b0);
      full_frame($sformatf("rand%0d", t), 2);
    end

    // start during DATA is ignored.
    build_random(2);
    add_checksum(1'b0);
    begin_frame("start_in_data");
    send_range(0, 3, 0);
    pulse_start();
    check("start_in_data_busy", 64'(busy), 64'd1);
    send_range(3, frame_q.size(), 1);
    end_frame("start_in_data");
    $display("frame start_in_data: writes=%0d done=%0b", got_q.size(), done);

    // Error, then a fresh start recovers.
    build_random(DEPTH + 1);
    full_frame("err_again", 0);
    build_random(3);
    add_checksum(1'b0);
    full_frame("recover", 1);

    // Asynchronous reset in the middle of DATA.
    build_random(3);
    add_checksum(1'b0);
    begin_frame("mid_reset");
    send_range(0, 3, 0);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (3) begin @(posedge clk); #1; end
    check("mid_reset_nwr", 64'(got_q.size()), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-load: writes=%0d busy=%0b", got_q.size(), busy);

    build_random(2);
    add_checksum(1'b0);
    full_frame("after_reset", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
